code_nco: RTL and testbench
===========================

# code_nco

Code-rate NCO for the tracking channel. A 32-bit phase accumulator, built on the existing `cla_32_bit` adder, produces chip, half-chip and code-epoch strobes plus the current chip index. These drive the PRN generator and the early/prompt/late correlators. Frequency-word updates from the tracking loop are accepted through a valid/ready handshake and applied only at code-epoch boundaries, so a code period never mixes two rates.

## Interface
- `CODE_LEN`, 1023: chips per code epoch; legal range 2..65535.
- `CHIP_W`, 16: width of `chip_idx`; must satisfy 2^CHIP_W ≥ CODE_LEN.
- `RESET_FCW`, 32'h0000_0000: active frequency word after reset.
- `clk` in 1: system clock; all state changes on the rising edge.
- `nrst` in 1: asynchronous, active-low reset.
- `en` in 1: advance the accumulator by one step on this edge.
- `phase_clr` in 1: synchronous clear of phase, chip index and strobes.
- `fcw_in` in 32: new code frequency word (phase increment per `en`).
- `fcw_valid` in 1: `fcw_in` is valid.
- `fcw_ready` out 1: a pending-word slot is free.
- `phase` out 32: accumulator phase (registered).
- `chip_idx` out CHIP_W: current chip, 0..CODE_LEN-1.
- `chip_stb` out 1: one-cycle pulse; a chip boundary was crossed.
- `half_stb` out 1: one-cycle pulse; the mid-chip point (2^31) was crossed.
- `epoch_stb` out 1: one-cycle pulse; `chip_idx` wrapped to 0.

## Operation
- State:
  - `phase` (32 bits).
  - `chip_idx`.
  - `fcw_act` (32 bits).
  - `fcw_pend` (32 bits) and `pend_v`.
  - Three strobe registers.
- Reset values: `phase`=0, `chip_idx`=0, `fcw_act`=RESET_FCW, `pend_v`=0, all strobes 0, `fcw_ready`=1.
- Adder: `sum, cout = phase + fcw_act`, with cin=0.
- Handshake:
  - `fcw_ready` = !`pend_v`.
  - Transfer occurs on an edge where `fcw_valid` && `fcw_ready`.
  - On transfer, `fcw_pend` ← `fcw_in` and `pend_v` ← 1.
  - If `fcw_in[31]`=1, the word is saturated to 32'h7FFF_FFFF, which caps the rate below clk/2.
- Advance, on an edge with `en`=1 and `phase_clr`=0:
  - `phase` ← `sum`.
  - `chip_stb` ← `cout`.
  - `half_stb` ← (!`phase[31]` & `sum[31]`) | (`cout` & `sum[31]`).
  - If `cout`: `chip_idx` ← (`chip_idx`==CODE_LEN-1) ? 0 : `chip_idx`+1.
  - `epoch_stb` ← `cout` & (`chip_idx`==CODE_LEN-1).
- Epoch apply: on an edge where `epoch_stb` is being set and `pend_v` was 1 before that edge:
  - `fcw_act` ← `fcw_pend` and `pend_v` ← 0.
  - The new word is used from the next add.
  - A word transferred on the same edge is not applied; it waits for the following epoch.
- Edge with `en`=0 and `phase_clr`=0: phase and index hold, all strobes ← 0.
- `phase_clr`=1 (priority over `en`):
  - `phase` ← 0, `chip_idx` ← 0, strobes ← 0.
  - If `pend_v`, the pending word is applied immediately (`fcw_act` ← `fcw_pend`, `pend_v` ← 0).
  - A handshake transfer on this edge is still accepted and becomes pending.
- `fcw_act`=0: the accumulator never moves and no strobes fire.
- Wrap: phase arithmetic is modulo 2^32. `cout` is the sole chip indicator, so exactly one chip per wrap is guaranteed by the fcw < 2^31 cap.

## Timing
- All outputs are registered. No combinational path from inputs to outputs except `fcw_ready`, which is registered via `pend_v`.
- Latency: the `en` edge updates `phase`, `chip_idx` and the strobes visible in the following cycle.
- Strobes last exactly one cycle, even with `en` held high.
- `epoch_stb` coincides with `chip_stb` and with `chip_idx`=0.
- `fcw_ready` deasserts the cycle after a transfer. It reasserts the cycle after the apply edge (epoch or clear).
- Reset mid-operation: `nrst` low forces all reset values asynchronously. Any pending word is discarded.

## Structure
- Shared package `gnss_pkg`:
  - `GPS_CA_LEN` = 1023.
  - `FCW_W` = 32.
  - typedef `fcw_t` = logic [31:0].
- One sub-module: the existing `cla_32_bit` instance for the phase add, with `cin` tied 0 and `pg`/`gg` unused.
- Chip counter and handshake logic stay inline.

## Test plan
- Basic stepping, CODE_LEN=4, RESET_FCW=32'h4000_0000, `en`=1 continuously:
  - phase runs 4000_0000, 8000_0000, C000_0000, 0000_0000.
  - `half_stb` after the 2nd `en` edge; `chip_stb` after the 4th.
  - `epoch_stb` after the 16th, with `chip_idx` back to 0.
- Update at epoch:
  - Transfer fcw=32'h2000_0000 mid-epoch; `fcw_ready` goes 0.
  - The old rate continues until `epoch_stb`; afterwards `chip_stb` fires every 8 `en`; `fcw_ready` returns 1.
- Saturation: transfer `fcw_in`=32'hFFFF_FFFF and apply it via `phase_clr`. The first add gives phase=7FFF_FFFF; the second gives FFFF_FFFE with `half_stb`=1 and `chip_stb`=0.
- `en` gaps: alternate `en` 1/0 with fcw=4000_0000.
  - Strobes fire only for one cycle after the crossing `en` edge.
  - phase holds during `en`=0 cycles.
- Clear priority:
  - Assert `phase_clr` and `en` together at phase=C000_0000, with a pending word.
  - Result: phase=0, `chip_idx`=0, no `chip_stb`, pending word active.
- Async reset: drop `nrst` mid-epoch with `pend_v`=1. All outputs return to reset values immediately, `fcw_ready`=1, and `fcw_act`=RESET_FCW.

Source files
------------

// File: rtl/gnss_pkg.sv
// rtl/gnss_pkg.sv - shared GNSS tracking constants and types
package gnss_pkg;

    localparam int unsigned GPS_CA_LEN = 1023;
    localparam int unsigned FCW_W      = 32;

    typedef logic [FCW_W-1:0] fcw_t;

endpackage

// File: rtl/cla_32_bit.sv
// rtl/cla_32_bit.sv - 32-bit carry-lookahead adder, 4-bit lookahead groups
module cla_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout,
    output logic        pg,
    output logic        gg
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic [7:0]  bg;
    logic [7:0]  bp;
    logic        g_acc;

    assign g = a & b;
    assign p = a ^ b;

    // Full lookahead inside each nibble; group carries ripple between nibbles.
    always_comb begin
        c     = '0;
        bg    = '0;
        bp    = '0;
        g_acc = 1'b0;
        c[0]  = cin;
        for (int k = 0; k < 8; k++) begin
            bg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            bp[k] = &p[4*k +: 4];
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = bg[k] | (bp[k] & c[4*k]);
            g_acc    = bg[k] | (bp[k] & g_acc);
        end
    end

    assign sum  = p ^ c[31:0];
    assign cout = c[32];
    assign pg   = &bp;
    assign gg   = g_acc;

endmodule

// File: rtl/code_nco.sv
// rtl/code_nco.sv - code-rate NCO with chip/half-chip/epoch strobes and epoch-aligned rate updates
module code_nco
    import gnss_pkg::*;
#(
    parameter int unsigned CODE_LEN  = GPS_CA_LEN,
    parameter int unsigned CHIP_W    = 16,
    parameter fcw_t        RESET_FCW = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              phase_clr,
    input  fcw_t              fcw_in,
    input  logic              fcw_valid,
    output logic              fcw_ready,
    output fcw_t              phase,
    output logic [CHIP_W-1:0] chip_idx,
    output logic              chip_stb,
    output logic              half_stb,
    output logic              epoch_stb
);

    localparam logic [CHIP_W-1:0] LAST_IDX = CHIP_W'(CODE_LEN - 1);

    fcw_t fcw_act;
    fcw_t fcw_pend;
    logic pend_v;
    fcw_t sum;
    logic cout;
    logic at_last;
    fcw_t fcw_sat;
    logic adder_pg_unused;
    logic adder_gg_unused;

    cla_32_bit u_add (
        .a    (phase),
        .b    (fcw_act),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout),
        .pg   (adder_pg_unused),
        .gg   (adder_gg_unused)
    );

    assign at_last   = (chip_idx == LAST_IDX);
    assign fcw_ready = !pend_v;
    // Words >= 2^31 would allow two boundaries per add; clamp just below.
    assign fcw_sat   = fcw_in[31] ? 32'h7FFF_FFFF : fcw_in;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            phase     <= '0;
            chip_idx  <= '0;
            chip_stb  <= 1'b0;
            half_stb  <= 1'b0;
            epoch_stb <= 1'b0;
            fcw_act   <= RESET_FCW;
            fcw_pend  <= '0;
            pend_v    <= 1'b0;
        end else begin
            // Transfer needs !pend_v and apply needs pend_v, so they never collide.
            if (fcw_valid && !pend_v) begin
                fcw_pend <= fcw_sat;
                pend_v   <= 1'b1;
            end
            if (phase_clr) begin
                phase     <= '0;
                chip_idx  <= '0;
                chip_stb  <= 1'b0;
                half_stb  <= 1'b0;
                epoch_stb <= 1'b0;
                if (pend_v) begin
                    fcw_act <= fcw_pend;
                    pend_v  <= 1'b0;
                end
            end else if (en) begin
                phase     <= sum;
                chip_stb  <= cout;
                half_stb  <= (!phase[31] & sum[31]) | (cout & sum[31]);
                epoch_stb <= cout & at_last;
                if (cout) begin
                    chip_idx <= at_last ? '0 : chip_idx + CHIP_W'(1);
                end
                if (cout && at_last && pend_v) begin
                    fcw_act <= fcw_pend;
                    pend_v  <= 1'b0;
                end
            end else begin
                chip_stb  <= 1'b0;
                half_stb  <= 1'b0;
                epoch_stb <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_code_nco.sv
// tb/tb_code_nco.sv - directed self-checking bench for code_nco
module tb_code_nco;

    logic        clk;
    logic        nrst;
    logic        en;
    logic        phase_clr;
    logic [31:0] fcw_in;
    logic        fcw_valid;
    logic        fcw_ready;
    logic [31:0] phase;
    logic [15:0] chip_idx;
    logic        chip_stb;
    logic        half_stb;
    logic        epoch_stb;

    int checks   = 0;
    int failures = 0;

    code_nco #(
        .CODE_LEN  (4),
        .CHIP_W    (16),
        .RESET_FCW (32'h4000_0000)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .en        (en),
        .phase_clr (phase_clr),
        .fcw_in    (fcw_in),
        .fcw_valid (fcw_valid),
        .fcw_ready (fcw_ready),
        .phase     (phase),
        .chip_idx  (chip_idx),
        .chip_stb  (chip_stb),
        .half_stb  (half_stb),
        .epoch_stb (epoch_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input logic [31:0] ph, input logic [15:0] idx,
                             input logic cs, input logic hs, input logic es, input logic rdy);
        check_eq({tag, ".phase"}, phase, ph);
        check_eq({tag, ".chip_idx"}, {16'h0, chip_idx}, {16'h0, idx});
        check_eq({tag, ".chip_stb"}, {31'h0, chip_stb}, {31'h0, cs});
        check_eq({tag, ".half_stb"}, {31'h0, half_stb}, {31'h0, hs});
        check_eq({tag, ".epoch_stb"}, {31'h0, epoch_stb}, {31'h0, es});
        check_eq({tag, ".fcw_ready"}, {31'h0, fcw_ready}, {31'h0, rdy});
    endtask

    initial begin
        nrst      = 1'b0;
        en        = 1'b0;
        phase_clr = 1'b0;
        fcw_in    = '0;
        fcw_valid = 1'b0;
        @(negedge clk);
        check_all("reset", 32'h0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        nrst = 1'b1;

        // Basic stepping: 4 en per chip, 4 chips per epoch.
        en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check_all($sformatf("basic%0d", k), 32'(k) << 30, 16'((k / 4) % 4),
                      (k % 4) == 0, (k % 4) == 2, k == 16, 1'b1);
        end

        // Update at epoch: old rate runs on until the epoch, then 8 en per chip.
        step();
        step();
        check_eq("upd.pre_phase", phase, 32'h8000_0000);
        fcw_in    = 32'h2000_0000;
        fcw_valid = 1'b1;
        step();
        fcw_valid = 1'b0;
        check_eq("upd.ready_low", {31'h0, fcw_ready}, 32'h0);
        check_eq("upd.old_rate", phase, 32'hC000_0000);
        for (int k = 4; k <= 16; k++) begin
            step();
            check_eq($sformatf("upd.phase%0d", k), phase, 32'(k) << 30);
            check_eq($sformatf("upd.epoch%0d", k), {31'h0, epoch_stb}, {31'h0, k == 16});
            check_eq($sformatf("upd.ready%0d", k), {31'h0, fcw_ready}, {31'h0, k == 16});
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            check_eq($sformatf("new.phase%0d", k), phase, 32'(k) << 29);
            check_eq($sformatf("new.chip%0d", k), {31'h0, chip_stb}, {31'h0, k == 8});
        end
        check_eq("new.idx", {16'h0, chip_idx}, 32'd1);

        // Saturation applied through phase_clr.
        en        = 1'b0;
        fcw_in    = 32'hFFFF_FFFF;
        fcw_valid = 1'b1;
        step();
        fcw_valid = 1'b0;
        check_eq("sat.ready_low", {31'h0, fcw_ready}, 32'h0);
        phase_clr = 1'b1;
        step();
        phase_clr = 1'b0;
        check_all("sat.clr", 32'h0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        en = 1'b1;
        step();
        check_all("sat.add1", 32'h7FFF_FFFF, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check_all("sat.add2", 32'hFFFF_FFFE, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1);

        // en gaps at 4000_0000.
        en        = 1'b0;
        fcw_in    = 32'h4000_0000;
        fcw_valid = 1'b1;
        step();
        fcw_valid = 1'b0;
        phase_clr = 1'b1;
        step();
        phase_clr = 1'b0;
        en = 1'b1; step(); check_all("gap1", 32'h4000_0000, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        en = 1'b0; step(); check_all("gap2", 32'h4000_0000, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        en = 1'b1; step(); check_all("gap3", 32'h8000_0000, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        en = 1'b0; step(); check_all("gap4", 32'h8000_0000, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        en = 1'b1; step(); check_all("gap5", 32'hC000_0000, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        en = 1'b0; step(); check_all("gap6", 32'hC000_0000, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        en = 1'b1; step(); check_all("gap7", 32'h0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        en = 1'b0; step(); check_all("gap8", 32'h0, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Clear beats en at C000_0000 and applies the pending word at once.
        en        = 1'b1;
        fcw_in    = 32'h1000_0000;
        fcw_valid = 1'b1;
        step();
        fcw_valid = 1'b0;
        step();
        step();
        check_all("clr.pre", 32'hC000_0000, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        phase_clr = 1'b1;
        step();
        phase_clr = 1'b0;
        check_all("clr.post", 32'h0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("clr.new_rate", phase, 32'h1000_0000);

        // Async reset mid-epoch with a pending word.
        fcw_in    = 32'h3000_0000;
        fcw_valid = 1'b1;
        step();
        fcw_valid = 1'b0;
        check_eq("arst.pre_ready", {31'h0, fcw_ready}, 32'h0);
        check_eq("arst.pre_phase", phase, 32'h2000_0000);
        #2;
        nrst = 1'b0;
        #1;
        check_all("arst.now", 32'h0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        nrst = 1'b1;
        step();
        check_eq("arst.reset_fcw", phase, 32'h4000_0000);
        check_eq("arst.ready", {31'h0, fcw_ready}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
